// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the PLL lock sequencer.
package pll_seq_pkg;

  localparam int TIMER_W = 16;
  localparam int CNT_W   = 8;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

endpackage

// File: rtl/sync_bit_2ff.sv
// Two-flop synchronizer for a single level signal; resets to 0.
module sync_bit_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so meta->q is a true two-stage shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences the PLL reset, qualifies lock, and releases the user-clock reset only after stable lock.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRIES   = 7
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             PLL_LOCKED,
  output logic             PLL_RST,
  output logic             RST_N_OUT,
  output logic             FAILED,
  output logic [CNT_W-1:0] RETRY_COUNT,
  output logic [CNT_W-1:0] LOCK_LOSS_COUNT
);

  localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RESET_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   RETRY_LAST   = CNT_W'(MAX_RETRIES);

  state_t             state, state_n;
  logic [TIMER_W-1:0] timer;
  logic [CNT_W-1:0]   retry_n, loss_n;
  logic               locked_s;
  logic               retry_req;

  sync_bit_2ff u_lock_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (PLL_LOCKED),
    .q     (locked_s)
  );

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_n   = state;
    retry_n   = RETRY_COUNT;
    loss_n    = LOCK_LOSS_COUNT;
    retry_req = 1'b0;

    case (state)
      RESET_PLL: if (timer == RST_LAST) state_n = WAIT_LOCK;
      WAIT_LOCK: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (locked_s)                   state_n   = STABILIZE;
        else if (timer == TIMEOUT_LAST) retry_req = 1'b1;
      end
      STABILIZE: begin
        if (!locked_s)                 retry_req = 1'b1;
        else if (timer == STABLE_LAST) state_n   = RUN;
      end
      RUN: begin
        if (!locked_s) begin
          state_n = RESET_PLL;
          retry_n = '0;
          if (LOCK_LOSS_COUNT != '1) loss_n = LOCK_LOSS_COUNT + 1'b1;
        end
      end
      FAIL:    state_n = FAIL;
      default: state_n = RESET_PLL;
    endcase

    if (retry_req) begin
      if (RETRY_COUNT == RETRY_LAST) begin
        state_n = FAIL;
      end else begin
        state_n = RESET_PLL;
        retry_n = RETRY_COUNT + 1'b1;
      end
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state           <= RESET_PLL;
      timer           <= '0;
      PLL_RST         <= 1'b1;
      RST_N_OUT       <= 1'b0;
      FAILED          <= 1'b0;
      RETRY_COUNT     <= '0;
      LOCK_LOSS_COUNT <= '0;
    end else begin
      state           <= state_n;
      timer           <= (state_n != state) ? '0 : timer + 1'b1;
      PLL_RST         <= (state_n == RESET_PLL) || (state_n == FAIL);
      RST_N_OUT       <= (state_n == RUN);
      FAILED          <= (state_n == FAIL);
      RETRY_COUNT     <= retry_n;
      LOCK_LOSS_COUNT <= loss_n;
    end
  end

endmodule
